// File: rtl/umult_accum.sv
// Frame accumulator for unsigned products: sums up to FRAME_LEN beats, then holds the result for a handshake.
// Optional macro UMULT_ACCUM_SAT_EN: clamp the accumulator to all-ones on overflow instead of wrapping.
module umult_accum #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 40,
    parameter int FRAME_LEN = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IN_WIDTH-1:0]              in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_WIDTH-1:0]             out_data,
    output logic [$clog2(FRAME_LEN+1)-1:0]   out_count,
    output logic                             out_ovf
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0] res_data_q, res_data_d;
    logic [CNT_W-1:0]     res_cnt_q, res_cnt_d;
    logic                 res_ovf_q, res_ovf_d;

    logic                 accept;
    logic                 close;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic [ACC_WIDTH-1:0] acc_add;
    logic                 ovf_add;
    logic [CNT_W-1:0]     cnt_inc;

    assign in_ready = (state_q == ACCUM) && !clr;
    assign accept   = in_valid && in_ready;

    // One extra bit on the adder exposes the carry used as the overflow indication.
    assign sum     = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, in_data};
    assign carry   = sum[ACC_WIDTH];
    assign ovf_add = ovf_q || carry;

`ifdef UMULT_ACCUM_SAT_EN
    // Once saturated the sticky flag keeps the accumulator pinned for the rest of the frame.
    assign acc_add = ovf_add ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    assign acc_add = sum[ACC_WIDTH-1:0];
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign close   = accept && (in_last || (cnt_inc == FRAME_LEN_C));

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        res_data_d = res_data_q;
        res_cnt_d  = res_cnt_q;
        res_ovf_d  = res_ovf_q;

        if (clr) begin
            state_d    = ACCUM;
            acc_d      = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            res_data_d = '0;
            res_cnt_d  = '0;
            res_ovf_d  = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (close) begin
                        state_d    = HOLD;
                        res_data_d = acc_add;
                        res_cnt_d  = cnt_inc;
                        res_ovf_d  = ovf_add;
                        acc_d      = '0;
                        cnt_d      = '0;
                        ovf_d      = 1'b0;
                    end else if (accept) begin
                        acc_d = acc_add;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_add;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d    = ACCUM;
                        res_data_d = '0;
                        res_cnt_d  = '0;
                        res_ovf_d  = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            res_data_q <= '0;
            res_cnt_q  <= '0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            res_data_q <= res_data_d;
            res_cnt_q  <= res_cnt_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_data  = res_data_q;
    assign out_count = res_cnt_q;
    assign out_ovf   = res_ovf_q;

endmodule

// File: tb/tb_umult_accum.sv
// Self-checking bench for umult_accum: directed cases plus a randomized run against a frame-sum model.
module tb_umult_accum;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // A: FRAME_LEN=4, ACC_WIDTH=40
    logic        a_in_valid = 0, a_in_ready, a_in_last = 0, a_out_valid, a_out_ready = 0, a_out_ovf;
    logic [15:0] a_in_data = 0;
    logic [39:0] a_out_data;
    logic [2:0]  a_out_count;
    // B: FRAME_LEN=4, ACC_WIDTH=17 (overflow cases)
    logic        b_in_valid = 0, b_in_ready, b_in_last = 0, b_out_valid, b_out_ready = 0, b_out_ovf;
    logic [15:0] b_in_data = 0;
    logic [16:0] b_out_data;
    logic [2:0]  b_out_count;
    // C: FRAME_LEN=1
    logic        c_in_valid = 0, c_in_ready, c_in_last = 0, c_out_valid, c_out_ready = 0, c_out_ovf;
    logic [15:0] c_in_data = 0;
    logic [39:0] c_out_data;
    logic [0:0]  c_out_count;

    umult_accum #(.IN_WIDTH(16), .ACC_WIDTH(40), .FRAME_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_count(a_out_count), .out_ovf(a_out_ovf));

    umult_accum #(.IN_WIDTH(16), .ACC_WIDTH(17), .FRAME_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_count(b_out_count), .out_ovf(b_out_ovf));

    umult_accum #(.IN_WIDTH(16), .ACC_WIDTH(40), .FRAME_LEN(1)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_count(c_out_count), .out_ovf(c_out_ovf));

    task automatic a_beat(input logic [15:0] d, input bit last);
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = d; a_in_last = last;
        @(posedge clk); #1;
    endtask

    task automatic a_idle();
        @(negedge clk);
        a_in_valid = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", a_out_valid); end
        n_checks++; if (a_out_data !== 40'd0) begin n_fail++; $display("FAIL reset_out_data: got %0h want 0", a_out_data); end
        n_checks++; if (a_out_count !== 3'd0) begin n_fail++; $display("FAIL reset_out_count: got %0d want 0", a_out_count); end
        n_checks++; if (a_out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %0b want 0", a_out_ovf); end
        n_checks++; if ({b_out_valid, c_out_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_bc_valid: got %0b want 00", {b_out_valid, c_out_valid}); end
        @(negedge clk); rst = 1'b0;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", a_in_ready); end
    endtask

    task automatic test_basic();
        @(negedge clk); a_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) a_beat(16'(i), 1'b0);
        n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", a_out_valid); end
        n_checks++; if (a_out_data !== 40'd10) begin n_fail++; $display("FAIL basic_data: got %0d want 10", a_out_data); end
        n_checks++; if (a_out_count !== 3'd4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", a_out_count); end
        n_checks++; if (a_out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %0b want 0", a_out_ovf); end
        a_idle();
        @(posedge clk); #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %0b want 0", a_out_valid); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back: got %0b want 1", a_in_ready); end
    endtask

    task automatic test_hold();
        @(negedge clk); a_out_ready = 1'b0;
        a_beat(16'd100, 1'b0);
        a_beat(16'd200, 1'b1);
        a_idle();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 40'd300 || a_out_count !== 3'd2 || a_in_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold_stable[%0d]: got v=%0b d=%0d c=%0d r=%0b want v=1 d=300 c=2 r=0", i, a_out_valid, a_out_data, a_out_count, a_in_ready);
            end
            @(posedge clk); #1;
        end
        @(negedge clk); a_out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: got v=%0b r=%0b want v=0 r=1", a_out_valid, a_in_ready); end
    endtask

    task automatic test_clr();
        a_beat(16'd5, 1'b0);
        a_beat(16'd6, 1'b0);
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = 16'd7; clr = 1'b1;
        #1;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready: got %0b want 0", a_in_ready); end
        @(posedge clk); #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_no_out: got %0b want 0", a_out_valid); end
        @(negedge clk); clr = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) a_beat(16'd1, 1'b0);
        n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 40'd4 || a_out_count !== 3'd4) begin
            n_fail++; $display("FAIL clr_next_frame: got v=%0b d=%0d c=%0d want v=1 d=4 c=4", a_out_valid, a_out_data, a_out_count);
        end
        // clr wins over a simultaneous output handshake in HOLD
        @(negedge clk); a_in_valid = 1'b0; clr = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_hold: got %0b want 0", a_out_valid); end
        @(negedge clk); clr = 1'b0; a_out_ready = 1'b0;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_hold_ready: got %0b want 1", a_in_ready); end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 4; i++) a_beat(16'(i), 1'b0);
        a_idle();
        n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 40'd10) begin n_fail++; $display("FAIL arst_pre: got v=%0b d=%0d want v=1 d=10", a_out_valid, a_out_data); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (a_out_valid !== 1'b0 || a_out_data !== 40'd0 || a_out_count !== 3'd0) begin
            n_fail++; $display("FAIL arst_immediate: got v=%0b d=%0d c=%0d want 0 0 0", a_out_valid, a_out_data, a_out_count);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_after: got v=%0b r=%0b want v=0 r=1", a_out_valid, a_in_ready); end
    endtask

    task automatic test_overflow();
        longint beats [2][3];
        int     nb [2];
        longint s, exp_d;
        bit     exp_o;
        beats[0] = '{65535, 65535, 65535}; nb[0] = 3;
        beats[1] = '{65535, 1, 0};         nb[1] = 2;
        for (int f = 0; f < 2; f++) begin
            s = 0;
            for (int i = 0; i < nb[f]; i++) begin
                @(negedge clk);
                b_in_valid = 1'b1; b_in_data = 16'(beats[f][i]); b_in_last = (i == nb[f] - 1); b_out_ready = 1'b0;
                @(posedge clk); #1;
                s += beats[f][i];
            end
            exp_o = (s >= (64'd1 << 17));
`ifdef UMULT_ACCUM_SAT_EN
            exp_d = exp_o ? (64'd1 << 17) - 1 : s;
`else
            exp_d = s % (64'd1 << 17);
`endif
            n_checks++; if (b_out_valid !== 1'b1 || b_out_data !== 17'(exp_d) || b_out_ovf !== exp_o || b_out_count !== 3'(nb[f])) begin
                n_fail++; $display("FAIL ovf_frame[%0d]: got v=%0b d=%0h o=%0b c=%0d want v=1 d=%0h o=%0b c=%0d",
                                   f, b_out_valid, b_out_data, b_out_ovf, b_out_count, 17'(exp_d), exp_o, nb[f]);
            end
            @(negedge clk); b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b1;
            @(posedge clk); #1;
            n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_release[%0d]: got %0b want 0", f, b_out_valid); end
        end
        @(negedge clk); b_out_ready = 1'b0;
    endtask

    task automatic test_frame1();
        logic [15:0] d;
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            @(negedge clk); c_in_valid = 1'b1; c_in_data = d; c_out_ready = 1'b0;
            @(posedge clk); #1;
            n_checks++; if (c_out_valid !== 1'b1 || c_out_data !== {24'd0, d} || c_out_count !== 1'b1) begin
                n_fail++; $display("FAIL frame1[%0d]: got v=%0b d=%0h c=%0d want v=1 d=%0h c=1", i, c_out_valid, c_out_data, c_out_count, d);
            end
            @(negedge clk); c_in_valid = 1'b0; c_out_ready = 1'b1;
            @(posedge clk); #1;
            n_checks++; if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1) begin n_fail++; $display("FAIL frame1_release[%0d]: got v=%0b r=%0b want v=0 r=1", i, c_out_valid, c_in_ready); end
        end
        @(negedge clk); c_out_ready = 1'b0;
    endtask

    // Model: a frame is the list of accepted beats, closed at 4 beats or in_last; result is its sum.
    task automatic test_random();
        longint fsum = 0, pdata = 0;
        int     fcnt = 0, pcnt = 0, frames = 0, cyc = 0;
        bit     pend = 0, v, l, ordy, pov;
        logic [15:0] d;
        while (frames < 1000 && cyc < 60000) begin
            @(negedge clk); cyc++;
            v = ($urandom_range(0, 9) < 7); d = 16'($urandom); l = ($urandom_range(0, 5) == 0); ordy = ($urandom_range(0, 1) == 1);
            a_in_valid = v; a_in_data = d; a_in_last = l; a_out_ready = ordy;
            #1;
            n_checks++; if (a_in_ready !== !pend || a_out_valid !== pend) begin
                n_fail++; $display("FAIL rand_hs cyc %0d: got r=%0b v=%0b want r=%0b v=%0b", cyc, a_in_ready, a_out_valid, !pend, pend);
            end
            if (pend) begin
                pov = (pdata >= (64'd1 << 40));
                n_checks++; if (a_out_data !== 40'(pdata) || a_out_count !== 3'(pcnt) || a_out_ovf !== pov) begin
                    n_fail++; $display("FAIL rand_result frame %0d: got d=%0h c=%0d o=%0b want d=%0h c=%0d o=%0b",
                                       frames, a_out_data, a_out_count, a_out_ovf, 40'(pdata), pcnt, pov);
                end
                if (ordy) begin pend = 0; frames++; end
            end else if (v) begin
                fsum += d; fcnt++;
                if (l || fcnt == 4) begin pend = 1; pdata = fsum; pcnt = fcnt; fsum = 0; fcnt = 0; end
            end
        end
        n_checks++; if (frames < 1000) begin n_fail++; $display("FAIL rand_timeout: got %0d frames want 1000", frames); end
        @(negedge clk); a_in_valid = 1'b0; a_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_clr();
        test_async_reset();
        test_overflow();
        test_frame1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/umult_accum.md
UMULT_ACCUM -- requirements
Module: umult_accum

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, width of the unsigned product consumed from the multiplier stage.
REQ-002 SHALL have parameter ACC_WIDTH, default 40, accumulator and result width; legal when ACC_WIDTH >= IN_WIDTH.
REQ-003 SHALL have parameter FRAME_LEN, default 16, products per result; legal when FRAME_LEN >= 1.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous reset, active-high.
REQ-006 SHALL have port clr, input, 1 bit, synchronous abort of the partial frame and any pending result.
REQ-007 SHALL have port in_valid, input, 1 bit, in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit, block accepts a beat.
REQ-009 SHALL have port in_data, input, IN_WIDTH bits, unsigned product.
REQ-010 SHALL have port in_last, input, 1 bit, the beat closes the frame early.
REQ-011 SHALL have port out_valid, output, 1 bit, result is held.
REQ-012 SHALL have port out_ready, input, 1 bit, consumer takes the result.
REQ-013 SHALL have port out_data, output, ACC_WIDTH bits, frame sum.
REQ-014 SHALL have port out_count, output, $clog2(FRAME_LEN+1) bits, beats in the frame.
REQ-015 SHALL have port out_ovf, output, 1 bit, the frame exceeded the ACC_WIDTH range.

Function
REQ-016 SHALL implement two states: ACCUM (collecting beats) and HOLD (result presented).
REQ-017 in_ready SHALL be 1 only in ACCUM with clr low; it is combinational from state and clr.
REQ-018 A beat SHALL be accepted when in_valid & in_ready; the accumulator adds in_data zero-extended to ACC_WIDTH, and the beat counter increments.
REQ-019 A frame SHALL close on an accepted beat that is either the FRAME_LEN-th beat or has in_last=1, whichever comes first.
REQ-020 On frame close, in the next cycle: out_data = final sum including the closing beat, out_count = beats accepted, out_ovf = frame overflow flag, out_valid = 1, state = HOLD; accumulator, counter and overflow flag zeroed.
REQ-021 Latency SHALL be exactly one cycle from the accepting edge of the closing beat to out_valid high.
REQ-022 In HOLD, out_data, out_count and out_ovf SHALL stay stable until handshake; out_valid SHALL not drop without out_ready, except on clr or rst.
REQ-023 On out_valid & out_ready, out_valid SHALL be 0 next cycle and state SHALL return to ACCUM; in_ready is 1 in that same next cycle.
REQ-024 in_valid without in_ready SHALL have no effect; in_data and in_last are ignored when not accepted.
REQ-025 clr=1 SHALL, next cycle: state ACCUM, accumulator, counter and flag zero, out_valid 0; clr overrides a simultaneous beat (not accepted) and a simultaneous output handshake.
REQ-026 With FRAME_LEN=1, every accepted beat SHALL close a frame with out_count=1.
REQ-027 Overflow SHALL be detected when the carry out of the ACC_WIDTH-bit add is set; the frame flag is sticky until the frame closes or clr.

Reset
REQ-028 While rst=1: state ACCUM, accumulator, counter, flag zero; out_valid=0, out_data=0, out_count=0, out_ovf=0; in_ready=0 is not required (it follows REQ-017).
REQ-029 Assertion of rst mid-frame or in HOLD SHALL discard all partial and pending data with no output handshake.

Configuration
REQ-030 Macro UMULT_ACCUM_SAT_EN defined: on overflow the accumulator SHALL clamp to all-ones and stay there for the rest of the frame; out_ovf=1.
REQ-031 Macro UMULT_ACCUM_SAT_EN undefined: the accumulator SHALL wrap modulo 2^ACC_WIDTH; out_ovf still reports the wrap.

Verification (FRAME_LEN=4, IN_WIDTH=16, ACC_WIDTH=40 unless stated)
REQ-032 Beats 1,2,3,4 back-to-back, out_ready=1 -> one cycle after beat 4: out_valid=1, out_data=10, out_count=4, out_ovf=0; in_ready=1 the cycle after.
REQ-033 Beats 100,200 with in_last on 200 -> out_data=300, out_count=2; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-034 ACC_WIDTH=17, beats 0xFFFF x3 -> with SAT_EN out_data=0x1FFFF, out_ovf=1; without it out_data=0x2FFFD mod 2^17=0x0FFFD, out_ovf=1.
REQ-035 Beats 5,6 then clr together with beat 7 -> no output; next beats 1,1,1,1 -> out_data=4, out_count=4.
REQ-036 rst pulsed asynchronously (between edges) while in HOLD with out_data=10 -> out_valid=0 and out_data=0 immediately, no handshake observed.
REQ-037 Random in_valid/out_ready gaps over 1000 frames -> every result equals the scoreboard sum, and no beat is accepted in HOLD.
